id_stage_reg: RTL
=================

Name: id_stage_reg

Overview:
- Parametrised successor decode stage for the 5-stage RV32 pipeline: decode, register file, immediate generation, load-use hazard control and the ID/EX pipeline register in one block.
- Sits between the IF/ID register and the execute stage. All EX-facing outputs are registered, which gives 1-cycle decode latency.
- Adds behaviour the previous generation lacks: synchronous reset, flush, an instruction-valid qualifier, and multi-cycle load-use stalls.

Parameters:
- Width, 32, datapath and register width in bits (≥32).
- LoadStall, 1, bubble cycles inserted per load-use hazard (1..3).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- id_pc  in  Width  PC of the instruction in ID.
- id_instr  in  32  instruction in ID.
- wb_we  in  1  write-back register write enable.
- wb_rd  in  5  write-back destination register.
- wb_data  in  Width  write-back data.
- flush  in  1  EX-resolved branch/jump taken; kill the instruction in ID.
- pc_en  out  1  PC update enable (0 = hold).
- ifid_en  out  1  IF/ID update enable (0 = hold).
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc  out  Width  registered PC.
- ex_rs1_data, ex_rs2_data  out  Width each  registered operands.
- ex_imm  out  Width  registered sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices.
- ex_alu_ctrl  out  4  {instr[30], instr[14:12]}.
- ex_ctrl  out  9  {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUop[1:0]}.

Behaviour:
- Reset:
  - All ex_* outputs are 0.
  - stall_cnt is 0.
  - All 32 registers are 0.
  - pc_en and ifid_en are 1 in the cycle after reset.
- Register file:
  - 32 x Width registers.
  - x0 always reads 0; writes to x0 are ignored.
  - Writes occur on the rising edge when wb_we is 1.
  - Reads are combinational.
- Decode (opcode -> ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUop):
  - R 0110011 -> 0,0,1,0,0,0,0,10
  - I-ALU 0010011 -> 1,0,1,0,0,0,0,10
  - Load 0000011 -> 1,1,1,1,0,0,0,00
  - Store 0100011 -> 1,0,0,0,1,0,0,00
  - Branch 1100011 -> 0,0,0,0,0,1,0,01
  - JAL 1101111 and JALR 1100111 -> 1,0,1,0,0,0,1,00
  - LUI 0110111 and AUIPC 0010111 -> 1,0,1,0,0,0,0,00
  - Any other opcode -> all 0.
- Immediate:
  - Formats I, S, B, J, U per the RV32I encodings.
  - Sign-extended from instr[31] to Width.
  - U-type is instr[31:12] followed by 12 zeros.
  - Other opcodes produce 0.
- Hazard:
  - hazard = id_valid & ex_valid & ex_ctrl[5] (MemRead) & (ex_rd != 0) & (ex_rd == rs1 | ex_rd == rs2).
  - rs1/rs2 compare only when the opcode uses that source.
- Stall counter:
  - If stall_cnt == 0 and hazard: load stall_cnt = LoadStall-1.
  - Else if stall_cnt != 0: decrement.
  - stall = hazard | (stall_cnt != 0).
  - pc_en = ifid_en = ~stall. These are combinational; the stall is visible in the same cycle.
- ID/EX update each rising edge, priority reset > flush > stall > normal:
  - flush: write a bubble (ex_valid = 0, ex_ctrl = 0, other fields don't-care but zeroed), clear stall_cnt, and drive pc_en = ifid_en = 1 that cycle.
  - stall: write a bubble; IF/ID and PC hold via the enables.
  - normal: capture all decoded fields; ex_valid = id_valid; ex_ctrl is forced to 0 when id_valid = 0.
- Boundary cases:
  - A hazard against rd = x0 never stalls.
  - LoadStall = 1 gives exactly one bubble.
  - Reset asserted mid-stall clears the counter immediately.
  - A write-back to the same register being read in the same cycle: see Optional Feature.

Optional Feature:
- Macro: FORWARD_WB_EN.
- Defined:
  - When wb_we = 1, wb_rd != 0 and wb_rd equals rs1 (or rs2), the corresponding operand captured into ID/EX is wb_data (write-through bypass).
- Undefined:
  - The operand captured is the pre-write register value.
  - The EX forwarding unit must then cover the WB distance.

Test Plan:
- Reset → ex_valid = 0, ex_ctrl = 0, pc_en = 1.
- Then write x5 = 0x0000_1234 via WB and decode "add x6, x5, x0" → next cycle ex_rs1_data = 0x1234, ex_ctrl = 9'b001000010, ex_rd = 6.
- "lw x7, 0(x1)" then "add x8, x7, x2", LoadStall = 1:
  - 1 cycle with pc_en = 0.
  - ID/EX bubble (ex_valid = 0).
  - The add enters EX one cycle later.
- The same load-use sequence with LoadStall = 3:
  - pc_en = 0 for exactly 3 cycles and 3 consecutive bubbles.
- Load to x0 followed by a use of x0 → no stall.
- Decode "beq" with imm = -8 → ex_imm = 0xFFFF_FFF8, ex_ctrl = 9'b000001001.
- flush asserted in the middle of a LoadStall = 3 stall → next cycle ex_valid = 0, stall_cnt = 0, pc_en = 1.
- Decode "addi x9, x0, -1" → ex_imm = 0xFFFF_FFFF.
- FORWARD_WB_EN defined, WB writes x3 = 0xA5 in the same cycle "add x4, x3, x3" decodes → ex_rs1_data = ex_rs2_data = 0xA5.
- FORWARD_WB_EN undefined, same stimulus → both operands equal the old x3 value.

Source files
------------

// File: rtl/id_stage_reg.sv
// id_stage_reg : RV32 decode stage plus ID/EX pipeline register.
//
// Contents: instruction decode, a 32 x Width register file, immediate
// generation, load-use hazard detection with a multi-cycle stall counter,
// and the registered ID/EX outputs. All EX-facing outputs are registered,
// so decode takes one cycle.
//
// Optional build macro: FORWARD_WB_EN. When it is defined, a write-back to
// rs1/rs2 in the same cycle passes wb_data straight into ID/EX. When it is
// undefined, ID/EX captures the value held before the write, and the EX
// forwarding unit has to cover that distance.
//
// Parameters:
//   Width     datapath/register width (>= 32)
//   LoadStall bubble cycles per load-use hazard (1..3)
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   id_valid/pc/instr    instruction held in IF/ID
//   wb_we/rd/data        register-file write port
//   flush                kill the instruction in ID (taken branch/jump in EX)
//   pc_en, ifid_en       combinational hold controls for PC and IF/ID
//   ex_*                 registered ID/EX fields; ex_ctrl is
//                        {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUop[1:0]}
module id_stage_reg #(
  parameter int Width     = 32,
  parameter int LoadStall = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [Width-1:0] id_pc,
  input  logic [31:0]      id_instr,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [Width-1:0] wb_data,
  input  logic             flush,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ex_valid,
  output logic [Width-1:0] ex_pc,
  output logic [Width-1:0] ex_rs1_data,
  output logic [Width-1:0] ex_rs2_data,
  output logic [Width-1:0] ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_ctrl,
  output logic [8:0]       ex_ctrl
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  // ---------------- decode + immediate ----------------
  logic [8:0]  ctrl;
  logic [31:0] imm32;
  logic        use_rs1, use_rs2;

  always_comb begin
    ctrl    = '0;
    imm32   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl = 9'b0_0_1_0_0_0_0_10; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_IALU: begin
        ctrl = 9'b1_0_1_0_0_0_0_10; use_rs1 = 1'b1;
        imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OP_LOAD: begin
        ctrl = 9'b1_1_1_1_0_0_0_00; use_rs1 = 1'b1;
        imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OP_STORE: begin
        ctrl = 9'b1_0_0_0_1_0_0_00; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      end
      OP_BR: begin
        ctrl = 9'b0_0_0_0_0_1_0_01; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                 id_instr[30:25], id_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl = 9'b1_0_1_0_0_0_1_00;
        imm32 = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                 id_instr[20], id_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl = 9'b1_0_1_0_0_0_1_00; use_rs1 = 1'b1;
        imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        ctrl = 9'b1_0_1_0_0_0_0_00;
        imm32 = {id_instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // ---------------- register file ----------------
  logic [Width-1:0] rf [32];
  logic [Width-1:0] rs1_val, rs2_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
`ifdef FORWARD_WB_EN
    // write-through: same-cycle write-back wins over the stored value
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1) rs1_val = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2) rs2_val = wb_data;
`endif
  end

  // ---------------- load-use hazard / stall ----------------
  logic [1:0] stall_cnt;
  logic       hazard, stall;

  assign hazard = id_valid & ex_valid & ex_ctrl[5] & (ex_rd != 5'd0) &
                  ((use_rs1 & (ex_rd == rs1)) | (use_rs2 & (ex_rd == rs2)));
  assign stall  = hazard | (stall_cnt != 2'd0);
  // a flush overrides the hold so the redirected fetch proceeds
  assign pc_en   = ~stall | flush;
  assign ifid_en = ~stall | flush;

  // The first bubble comes from the hazard itself; the counter supplies
  // the remaining LoadStall-1, since ex_valid is 0 by then.
  always_ff @(posedge clk) begin
    if (reset || flush)
      stall_cnt <= '0;
    else if (stall_cnt == 2'd0 && hazard)
      stall_cnt <= 2'(LoadStall - 1);
    else if (stall_cnt != 2'd0)
      stall_cnt <= stall_cnt - 2'd1;
  end

  // ---------------- ID/EX register ----------------
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_alu_ctrl <= '0;
      ex_ctrl     <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= rs1_val;
      ex_rs2_data <= rs2_val;
      ex_imm      <= Width'($signed(imm32));
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rd       <= rd;
      ex_alu_ctrl <= {id_instr[30], id_instr[14:12]};
      ex_ctrl     <= id_valid ? ctrl : 9'd0;
    end
  end

endmodule
